// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
//
// Time-multiplexed scan controller for a 4-column x 8-row LED matrix.
// It holds a double-buffered 32-bit frame and drives one column at a time.
// Each column slot starts with a short blanking window (all columns off,
// rows dark) to prevent ghosting. The rest of the slot is the drive phase,
// where a 16-level global PWM gates the row data.
//
// Ports
//   clk         in   1   system clock
//   rst_n       in   1   synchronous active-low reset
//   enable      in   1   1 = scanning, 0 = matrix dark and scan parked at col 0
//   brightness  in   4   PWM on-time N/16 during drive phase (0 = off)
//   fb_data     in   32  frame; bits [8c+7:8c] are rows 8..1 of column c
//   fb_valid    in   1   fb_data valid
//   fb_ready    out  1   shadow buffer empty; accept on fb_valid & fb_ready
//   led         out  8   row drive, active-high, led[0] = led1
//   lcol        out  4   column select, active-low, lcol[0] = lcol1
//   frame_tick  out  1   one-cycle pulse on the last cycle of column 3
//
// Scan phase (decoded from enable and slot counter)
//   state    | meaning
//   PH_IDLE  | enable low: outputs dark, counters parked at col 0 / slot 0
//   PH_BLANK | slot_cnt < BLANK_CYCLES: all columns off, rows dark
//   PH_DRIVE | remainder of slot: one column low, rows gated by PWM
//
// All pins are registered, so they show the counter state of the
// previous cycle.
// -----------------------------------------------------------------------------
module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 3000,
    parameter int BLANK_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  brightness,
    input  logic [31:0] fb_data,
    input  logic        fb_valid,
    output logic        fb_ready,
    output logic [7:0]  led,
    output logic [3:0]  lcol,
    output logic        frame_tick
);

    localparam int SW = $clog2(DWELL_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DWELL_CYCLES - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    phase_t phase;

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    pwm_cnt_q, pwm_cnt_d;
    logic [3:0]    bright_q, bright_d;
    logic [31:0]   active_q, active_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [7:0]    led_q, led_d;
    logic [3:0]    lcol_q, lcol_d;
    logic          frame_tick_q, frame_tick_d;

    logic slot_last;
    logic frame_end;
    logic accept;

    always_comb begin
        if (!enable) begin
            phase = PH_IDLE;
        end else if (slot_cnt_q < BLANK_END) begin
            phase = PH_BLANK;
        end else begin
            phase = PH_DRIVE;
        end
    end

    assign slot_last = (slot_cnt_q == SLOT_LAST);
    assign frame_end = enable && slot_last && (col_q == 2'd3);
    // fb_ready comes straight from pending_q, so it never depends
    // combinationally on fb_valid.
    assign accept    = fb_valid && !pending_q;

    always_comb begin
        slot_cnt_d   = slot_cnt_q;
        col_d        = col_q;
        pwm_cnt_d    = pwm_cnt_q;
        bright_d     = bright_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        led_d        = 8'h00;
        lcol_d       = 4'hF;
        frame_tick_d = 1'b0;

        // Brightness is latched once per slot so the PWM duty cannot change
        // part-way through a column.
        if (slot_cnt_q == '0) begin
            bright_d = brightness;
        end

        case (phase)
            PH_IDLE: begin
                slot_cnt_d = '0;
                col_d      = 2'd0;
                pwm_cnt_d  = 4'd0;
            end
            PH_BLANK: begin
                slot_cnt_d = slot_cnt_q + 1'b1;
                // Held at zero so the first drive cycle sees pwm_cnt == 0.
                pwm_cnt_d  = 4'd0;
            end
            PH_DRIVE: begin
                lcol_d    = ~(4'b0001 << col_q);
                if (pwm_cnt_q < bright_q) begin
                    led_d = active_q[{col_q, 3'b000} +: 8];
                end
                pwm_cnt_d = pwm_cnt_q + 4'd1;
                if (slot_last) begin
                    slot_cnt_d = '0;
                    col_d      = col_q + 2'd1;
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            default: begin
                slot_cnt_d = '0;
                col_d      = 2'd0;
                pwm_cnt_d  = 4'd0;
            end
        endcase

        frame_tick_d = frame_end;

        // Accept needs pending low and the swap needs pending high, so the
        // two never happen in the same cycle.
        if (accept) begin
            shadow_d  = fb_data;
            pending_d = 1'b1;
        end else if (frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            col_q        <= 2'd0;
            pwm_cnt_q    <= 4'd0;
            bright_q     <= 4'd0;
            active_q     <= 32'h0;
            shadow_q     <= 32'h0;
            pending_q    <= 1'b0;
            led_q        <= 8'h00;
            lcol_q       <= 4'hF;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            col_q        <= col_d;
            pwm_cnt_q    <= pwm_cnt_d;
            bright_q     <= bright_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            led_q        <= led_d;
            lcol_q       <= lcol_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign fb_ready   = ~pending_q;
    assign led        = led_q;
    assign lcol       = lcol_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

    localparam int DWELL = 40;
    localparam int BLANK = 4;
    localparam int FRAME = 4 * DWELL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  brightness;
    logic [31:0] fb_data;
    logic        fb_valid;
    logic        fb_ready;
    logic [7:0]  led;
    logic [3:0]  lcol;
    logic        frame_tick;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .brightness(brightness),
        .fb_data   (fb_data),
        .fb_valid  (fb_valid),
        .fb_ready  (fb_ready),
        .led       (led),
        .lcol      (lcol),
        .frame_tick(frame_tick)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Frames accepted by the DUT but not yet swapped into the active buffer.
    logic [31:0] sb_q [$];
    logic [31:0] exp_active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample at the falling edge. The handshake is judged
    // on the input values present before the rising edge.
    task automatic step();
        logic hs;
        logic inv_ok;
        hs = rst_n && fb_valid && fb_ready;
        @(negedge clk);
        if (rst_n && frame_tick === 1'b1 && sb_q.size() > 0) begin
            exp_active = sb_q.pop_front();
        end
        if (hs) begin
            sb_q.push_back(fb_data);
            fb_valid = 1'b0;
        end
        inv_ok = (lcol == 4'hF) || $onehot(~lcol);
        chk("lcol_one_cold", 32'(inv_ok), 32'd1);
        inv_ok = !((lcol == 4'hF) && (led != 8'h00));
        chk("dark_when_blank", 32'(inv_ok), 32'd1);
    endtask

    task automatic wait_tick(input int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if (frame_tick === 1'b1) return;
        end
        chk("wait_tick_timeout", 32'(frame_tick), 32'd1);
    endtask

    // Checks one full frame starting at a column-0 slot start. Optional
    // injections of frames and a brightness change at given cycle indices.
    task automatic check_frame(input string tag,
                               input int inj_i, input logic [31:0] inj_d,
                               input int inj2_i, input logic [31:0] inj2_d,
                               input int chg_i, input logic [3:0] chg_b);
        logic [31:0] cur;
        logic [3:0]  slot_b;
        cur    = exp_active;
        slot_b = 4'd0;
        for (int i = 0; i < FRAME; i++) begin
            int col;
            int s;
            logic [7:0] exp_led;
            logic [3:0] exp_lcol;
            col = i / DWELL;
            s   = i % DWELL;
            if (i == inj_i) begin
                fb_data  = inj_d;
                fb_valid = 1'b1;
            end
            if (i == inj2_i) begin
                fb_data  = inj2_d;
                fb_valid = 1'b1;
            end
            if (i == chg_i) brightness = chg_b;
            if (s == 0) slot_b = brightness;
            step();
            if (s < BLANK) begin
                exp_lcol = 4'hF;
                exp_led  = 8'h00;
            end else begin
                exp_lcol = ~(4'b0001 << col);
                exp_led  = (((s - BLANK) % 16) < int'(slot_b)) ? cur[8*col +: 8] : 8'h00;
            end
            chk({tag, "_lcol"}, 32'(lcol), 32'(exp_lcol));
            chk({tag, "_led"}, 32'(led), 32'(exp_led));
            chk({tag, "_tick"}, 32'(frame_tick), 32'(i == FRAME - 1));
            chk({tag, "_ready"}, 32'(fb_ready), 32'(sb_q.size() == 0));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        brightness = 4'd15;
        fb_data    = 32'h0;
        fb_valid   = 1'b0;
        exp_active = 32'h0;
        repeat (3) step();

        // Get a frame into the active buffer and another into the shadow.
        rst_n    = 1'b1;
        fb_data  = 32'hFFFF_FFFF;
        fb_valid = 1'b1;
        wait_tick(2 * FRAME);
        check_frame("pre", -1, 32'h0, -1, 32'h0, -1, 4'd0);
        fb_data  = 32'h0F0F_0F0F;
        fb_valid = 1'b1;
        repeat (60) step();
        chk("pre_reset_ready", 32'(fb_ready), 32'd0);

        // Mid-scan reset discards both buffers.
        rst_n = 1'b0;
        sb_q.delete();
        exp_active = 32'h0;
        for (int r = 0; r < 5; r++) begin
            step();
            chk("rst_led", 32'(led), 32'h00);
            chk("rst_lcol", 32'(lcol), 32'hF);
            chk("rst_ready", 32'(fb_ready), 32'd1);
            chk("rst_tick", 32'(frame_tick), 32'd0);
        end
        rst_n = 1'b1;

        // First frame after reset is dark; the new frame swaps in at its end.
        check_frame("post_reset", 0, 32'h8040_2010, -1, 32'h0, -1, 4'd0);
        check_frame("scan", -1, 32'h0, -1, 32'h0, -1, 4'd0);

        // A mid-frame, B held while not ready.
        check_frame("hs1", 20, 32'h1122_3344, 60, 32'hAA55_C33C, -1, 4'd0);
        check_frame("hs2", -1, 32'h0, -1, 32'h0, -1, 4'd0);
        check_frame("hs3", -1, 32'h0, -1, 32'h0, -1, 4'd0);

        // PWM duty, then a mid-slot brightness change, then fully off.
        check_frame("pwm4", -1, 32'h0, -1, 32'h0, 0, 4'd4);
        check_frame("pwm_mid", -1, 32'h0, -1, 32'h0, 50, 4'd0);
        check_frame("pwm0", -1, 32'h0, -1, 32'h0, -1, 4'd0);

        // Drop enable during column 2 drive.
        brightness = 4'd15;
        repeat (100) step();
        chk("pre_drop_lcol", 32'(lcol), 32'hB);
        enable = 1'b0;
        for (int r = 0; r < 10; r++) begin
            step();
            chk("off_lcol", 32'(lcol), 32'hF);
            chk("off_led", 32'(led), 32'h00);
            chk("off_tick", 32'(frame_tick), 32'd0);
        end
        enable = 1'b1;
        check_frame("reenable", -1, 32'h0, -1, 32'h0, -1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
